fifo_axis_reader: RTL and testbench
===================================

Name: fifo_axis_reader

Overview:
- Downstream drain stage for the synchronous FIFO wrapper: issues rd_en, captures the read data, and re-presents it as an AXI4-Stream master with tlast framing.
- Absorbs the FIFO's fixed 1-cycle read latency through a 2-entry output buffer, so sustained throughput is 1 beat/clk with no bubbles under continuous tready.
- Sits between the FIFO wrapper and any AXI-Stream consumer (DMA, packetiser) in the same clock domain.

Parameters:
- DATA_WIDTH, 32, width of fifo_dout and m_axis_tdata; must equal the FIFO read width.
- PKT_LEN, 16, beats per packet; tlast is asserted on beat PKT_LEN-1; legal range 1..65535.
- CNT_WIDTH, 16, width of the pkt_count and beat counter registers.

Ports:
- clk  in  1  single clock, shared with the FIFO.
- resetn  in  1  asynchronous, active-low reset.
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read enable.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready from the consumer.
- m_axis_tlast  out  1  last beat of a packet.
- pkt_count  out  CNT_WIDTH  number of completed packets; wraps at 2^CNT_WIDTH.
- busy  out  1  high while data is in flight or buffered, or a packet is partially sent.

Behaviour:
- Reset (resetn=0, asynchronous):
  - fifo_rd_en=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, pkt_count=0, busy=0.
  - Buffer occupancy=0, in-flight flag=0, beat counter=0.
- Pop: occurs in a cycle when m_axis_tvalid && m_axis_tready.
- Read issue:
  - fifo_rd_en = !fifo_empty && (occ + inflight - pop) < 2.
  - Combinational on m_axis_tready; never asserted while fifo_empty=1.
- inflight: a register set to 1 in the cycle after fifo_rd_en=1, else 0. When inflight=1, fifo_dout is written into the buffer tail that cycle.
- Buffer:
  - 2-entry FIFO made of registers; head drives m_axis_tdata.
  - m_axis_tvalid = (occ != 0).
  - Data and tlast of the head stay stable while tvalid && !tready.
  - Simultaneous push and pop keeps occ unchanged and preserves order.
  - Invariant occ + inflight <= 2 at all times.
- tlast:
  - The beat counter advances on each push, not on each pop, and tlast is stored alongside the data in the buffer.
  - A beat is tagged last when counter == PKT_LEN-1; the counter then wraps to 0.
  - With PKT_LEN=1, every beat is tagged last.
- pkt_count: increments on a pop of a beat tagged last.
- busy = occ!=0 || inflight || beat counter!=0.
- Boundaries:
  - fifo_empty rising while a read is in flight: the in-flight beat is still captured.
  - tready held low with the buffer full: rd_en stays 0; no FIFO data is lost.
  - Reset mid-packet: buffered and in-flight data are discarded and the counter returns to 0. The FIFO is reset by the same system reset, so no stale beat is ever captured after reset.
- Latency: first beat appears on m_axis_tvalid 2 cycles after fifo_empty falls (rd_en in cycle 0, capture in cycle 1, valid visible in cycle 2).

Decomposition:
- Shared package: the AXIS beat struct (data, last) and the PKT_LEN and CNT_WIDTH defaults, shared with the upstream packer.
- One natural sub-module: axis_skid_buf2, the 2-entry register buffer with occupancy output, reusable for other stream stages.
- Read-issue logic and the beat and packet counters stay in the top level.

Test Plan:
- Streaming: FIFO preloaded with 0..63, tready=1 constant, PKT_LEN=16 -> 64 beats in order on 64 consecutive cycles after a 2-cycle latency; tlast on beats 15/31/47/63; pkt_count=4; busy=0 at the end.
- Backpressure: tready=0 for 10 cycles from the second beat -> occ=2, rd_en=0, tdata holds value 1; after release, values 1..N continue with no loss or duplication.
- Random tready: 50% random tready with random FIFO fill gaps -> scoreboard matches the order of 1000 beats; occ+inflight never exceeds 2; rd_en never asserted while empty.
- Drain race: single word 0xA5 written, tready=0 -> empty rises while the read is in flight; 0xA5 is still captured and emitted when tready=1; exactly one beat.
- Degenerate packet length: PKT_LEN=1, 5 words -> tlast=1 on every beat; pkt_count=5.
- Mid-packet reset: resetn pulsed low after beat 7 of 16 -> outputs go to 0 asynchronously; after release, the next packet's tlast lands on its 16th beat and pkt_count restarts from 0.

Source files
------------

// File: rtl/fifo_axis_reader_pkg.sv
// ---------------------------------------------------------------------------
// fifo_axis_reader_pkg
//   Shared types and defaults for the FIFO -> AXI4-Stream drain path. The
//   upstream packer uses the same beat layout and packet-length defaults, so
//   both sides agree on framing without duplicating constants.
//
//   Contents:
//     AXIS_DW        default stream data width
//     PKT_LEN_DEF    default beats per packet
//     CNT_WIDTH_DEF  default width of beat / packet counters
//     axis_beat_t    one stream beat (tlast flag + data) at the default width
//     pkt_last_idx   counter value of the final beat of a packet
// ---------------------------------------------------------------------------
package fifo_axis_reader_pkg;

    localparam int AXIS_DW       = 32;
    localparam int PKT_LEN_DEF   = 16;
    localparam int CNT_WIDTH_DEF = 16;

    // last sits above data so {last, data} packs directly into a skid-buffer
    // entry of width AXIS_DW+1.
    typedef struct packed {
        logic               last;
        logic [AXIS_DW-1:0] data;
    } axis_beat_t;

    // Beat index (0-based) that closes a packet of len beats.
    function automatic int unsigned pkt_last_idx(input int unsigned len);
        return len - 1;
    endfunction

endpackage : fifo_axis_reader_pkg

// File: rtl/fifo_axis_reader_skid.sv
// ---------------------------------------------------------------------------
// axis_skid_buf2
//   Two-entry register FIFO used as an output buffer for stream stages. The
//   head entry drives the output directly, so data out is a flop with no
//   read-side mux delay.
//
//   Ports:
//     clk_i    clock
//     rst_ni   asynchronous active-low reset (clears occupancy and entries)
//     push_i   write din_i into the tail this cycle
//     din_i    entry to write
//     pop_i    consumer ready; the head is removed when valid_o && pop_i
//     dout_o   head entry
//     occ_o    occupancy, 0..2
//     valid_o  head holds an entry (occ_o != 0)
//
//   The caller must not push into a full buffer unless it pops in the same
//   cycle; such a push is dropped rather than overwriting buffered data.
// ---------------------------------------------------------------------------
module axis_skid_buf2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [1:0]       occ_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             pop_ok;
    logic             push_ok;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        pop_ok  = pop_i && (occ_q != 2'd0);
        push_ok = push_i && ((occ_q != 2'd2) || pop_ok);

        if (push_ok && pop_ok) begin
            // Occupancy unchanged; the older tail entry moves up so order holds.
            if (occ_q == 2'd2) begin
                head_d = tail_q;
                tail_d = din_i;
            end else begin
                head_d = din_i;
            end
        end else if (push_ok) begin
            if (occ_q == 2'd0) begin
                head_d = din_i;
            end else begin
                tail_d = din_i;
            end
            occ_d = occ_q + 2'd1;
        end else if (pop_ok) begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign dout_o  = head_q;
    assign occ_o   = occ_q;
    assign valid_o = (occ_q != 2'd0);

endmodule : axis_skid_buf2

// File: rtl/fifo_axis_reader.sv
// ---------------------------------------------------------------------------
// fifo_axis_reader
//   Drains a synchronous FIFO (1-cycle read latency) and re-presents the data
//   as an AXI4-Stream master with fixed-length tlast framing. A 2-entry output
//   buffer hides the read latency so a continuously ready consumer sees one
//   beat per clock.
//
//   Ports:
//     clk            clock shared with the FIFO
//     resetn         asynchronous active-low reset
//     fifo_dout      FIFO read data, valid the cycle after fifo_rd_en
//     fifo_empty     FIFO empty flag
//     fifo_rd_en     FIFO read enable
//     m_axis_tdata   stream data
//     m_axis_tvalid  stream valid
//     m_axis_tready  stream ready from consumer
//     m_axis_tlast   last beat of a PKT_LEN-beat packet
//     pkt_count      completed packets (wraps)
//     busy           data buffered/in flight or a packet partially sent
// ---------------------------------------------------------------------------
module fifo_axis_reader
    import fifo_axis_reader_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DW,
    parameter int PKT_LEN    = PKT_LEN_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(pkt_last_idx(PKT_LEN));

    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q,  pkt_cnt_d;

    logic [1:0]           occ;
    logic [DATA_WIDTH:0]  head;
    logic                 head_vld;
    logic                 pop;
    logic                 tag_last;
    logic [2:0]           load;

    assign pop = head_vld && m_axis_tready;

    // Slots already committed for the next cycle: buffered + in flight, less
    // the one leaving now. Counting the pop lets a read issue in the same
    // cycle a beat drains, which is what keeps the stream gap-free.
    assign load = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

    // The resetn term keeps the read strobe low during reset even if the
    // empty flag has not yet settled.
    assign fifo_rd_en = resetn && !fifo_empty && (load < 3'd2);

    // Framing is decided at capture time and travels with the data, so a
    // stalled consumer cannot skew tlast relative to its beat.
    assign tag_last = (beat_cnt_q == LAST_IDX);

    always_comb begin
        inflight_d = fifo_rd_en;
        beat_cnt_d = beat_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (inflight_q) begin
            beat_cnt_d = tag_last ? '0 : beat_cnt_q + 1'b1;
        end
        if (pop && head[DATA_WIDTH]) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight_q <= 1'b0;
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    axis_skid_buf2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .push_i  (inflight_q),
        .din_i   ({tag_last, fifo_dout}),
        .pop_i   (m_axis_tready),
        .dout_o  (head),
        .occ_o   (occ),
        .valid_o (head_vld)
    );

    assign m_axis_tdata  = head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = head[DATA_WIDTH];
    assign m_axis_tvalid = head_vld;
    assign pkt_count     = pkt_cnt_q;
    assign busy          = (occ != 2'd0) || inflight_q || (beat_cnt_q != '0);

endmodule : fifo_axis_reader

// File: tb/tb_fifo_axis_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_axis_reader
//   Randomised bench for fifo_axis_reader. A queue stands in for the FIFO
//   (1-cycle read latency), a second queue holds words read but not yet
//   emitted, and framing is predicted from the count of beats emitted since
//   reset. A second instance with PKT_LEN=1 shares all stimulus.
// ---------------------------------------------------------------------------
module tb_fifo_axis_reader;

    localparam int DW = 32;
    localparam int PL = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          tready = 1'b0;

    logic          rd_en, tvalid, tlast, busy;
    logic [DW-1:0] tdata;
    logic [15:0]   pkt_count;
    logic          rd_en1, tvalid1, tlast1, busy1;
    logic [DW-1:0] tdata1;
    logic [15:0]   pkt_count1;

    always #5 clk = ~clk;

    fifo_axis_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(rd_en), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .pkt_count(pkt_count), .busy(busy)
    );

    fifo_axis_reader #(.DATA_WIDTH(DW), .PKT_LEN(1), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .resetn(resetn), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(rd_en1), .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1),
        .m_axis_tready(tready), .m_axis_tlast(tlast1), .pkt_count(pkt_count1), .busy(busy1)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] fq[$];   // FIFO contents
    logic [DW-1:0] sb[$];   // read from FIFO, not yet emitted
    logic [DW-1:0] pend = '0;
    int beat_idx  = 0;      // beats emitted since reset
    int exp_pkts  = 0;
    int exp_pkts1 = 0;
    int npops     = 0;
    int cyc       = 0;
    int first_pop = -1;
    int last_pop  = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: called at a falling edge, drives inputs, samples 1ns later
    // and returns at the next falling edge.
    task automatic step(input bit rdy);
        logic [DW-1:0] w;
        bit            is_last;
        fifo_dout  = pend;
        tready     = rdy;
        fifo_empty = (fq.size() == 0);
        #1;
        chk("rd_empty", 64'(rd_en && fifo_empty), 0);
        chk("rd_en1", 64'(rd_en1), 64'(rd_en));
        chk("tvalid1", 64'(tvalid1), 64'(tvalid));
        chk("pkt_cnt", 64'(pkt_count), 64'(exp_pkts & 16'hFFFF));
        chk("pkt_cnt1", 64'(pkt_count1), 64'(exp_pkts1 & 16'hFFFF));
        if (rd_en && fq.size() != 0) begin
            pend = fq.pop_front();
            sb.push_back(pend);
        end
        if (tvalid && tready) begin
            if (sb.size() == 0) begin
                chk("beat_no_src", 1, 0);
            end else begin
                w       = sb.pop_front();
                is_last = ((beat_idx % PL) == PL - 1);
                chk("tdata", 64'(tdata), 64'(w));
                chk("tlast", 64'(tlast), 64'(is_last));
                chk("tdata1", 64'(tdata1), 64'(w));
                chk("tlast1", 64'(tlast1), 1);
                beat_idx++;
                if (is_last) exp_pkts++;
                exp_pkts1++;
            end
            npops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        // Words read but not emitted = buffered + in flight.
        chk("occ_max", 64'(sb.size() <= 2), 1);
        cyc++;
        if (cyc > 60000) begin
            $display("FAIL watchdog: cycles %0d limit 60000", cyc);
            $fatal(1);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int g = 0;
        while ((fq.size() != 0 || sb.size() != 0) && g < budget) begin
            step(1'b1);
            g++;
        end
        if (g >= budget) chk("drain_timeout", 1, 0);
        step(1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tvalid"}, 64'(tvalid), 0);
        chk({tag, "_tlast"}, 64'(tlast), 0);
        chk({tag, "_tdata"}, 64'(tdata), 0);
        chk({tag, "_rd_en"}, 64'(rd_en), 0);
        chk({tag, "_pkt"}, 64'(pkt_count), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_pkt1"}, 64'(pkt_count1), 0);
        chk({tag, "_busy1"}, 64'(busy1), 0);
    endtask

    // Reset asserted between edges so the clearing is visibly asynchronous.
    task automatic do_reset(input string tag);
        #2 resetn = 1'b0;
        #1 chk_zero(tag);
        fq.delete();
        sb.delete();
        beat_idx   = 0;
        exp_pkts   = 0;
        exp_pkts1  = 0;
        fifo_empty = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int t0, p0, g;
        logic [15:0] p1;

        #1 resetn = 1'b0;
        #2 chk_zero("rst");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Streaming: 64 preloaded words, consumer always ready.
        for (int i = 0; i < 64; i++) fq.push_back(DW'(i));
        t0 = cyc; p0 = npops; first_pop = -1;
        repeat (70) step(1'b1);
        chk("lat", 64'(first_pop - t0), 2);
        chk("gapless", 64'(last_pop - first_pop), 63);
        chk("stream_beats", 64'(npops - p0), 64);
        chk("stream_pkts", 64'(pkt_count), 4);
        chk("stream_busy", 64'(busy), 0);

        // Backpressure from the second beat.
        for (int i = 0; i < 20; i++) fq.push_back(DW'(i));
        p0 = npops; g = 0;
        while (npops == p0 && g < 10) begin step(1'b1); g++; end
        chk("bp_first", 64'(npops - p0), 1);
        for (int i = 0; i < 10; i++) begin
            if (i >= 1) begin
                chk("bp_tdata", 64'(tdata), 1);
                chk("bp_tvalid", 64'(tvalid), 1);
                chk("bp_rd_en", 64'(rd_en), 0);
            end
            step(1'b0);
        end
        drain(100);
        chk("bp_beats", 64'(npops - p0), 20);

        // Drain race: single word, empty rises while its read is in flight.
        fq.push_back(32'hA5);
        repeat (4) step(1'b0);
        chk("race_tvalid", 64'(tvalid), 1);
        chk("race_tdata", 64'(tdata), 32'hA5);
        chk("race_rd_en", 64'(rd_en), 0);
        p0 = npops;
        repeat (5) step(1'b1);
        chk("race_beats", 64'(npops - p0), 1);

        // PKT_LEN=1 instance: every beat closes a packet.
        p1 = pkt_count1;
        for (int i = 0; i < 5; i++) fq.push_back($urandom);
        drain(50);
        chk("len1_pkts", 64'(16'(pkt_count1 - p1)), 5);

        // Random ready and random FIFO fill gaps.
        p0 = npops; g = 0;
        while (npops - p0 < 1000 && g < 8000) begin
            if ($urandom_range(0, 99) < 45) fq.push_back($urandom);
            step(1'($urandom_range(0, 1)));
            g++;
        end
        chk("rand_beats", 64'(npops - p0 >= 1000), 1);
        drain(2000);

        // Mid-packet reset after the 7th beat of a packet.
        for (int i = 0; i < 40; i++) fq.push_back(32'h1000 + DW'(i));
        g = 0;
        do begin step(1'b1); g++; end while ((beat_idx % PL) != 7 && g < 100);
        chk("mid_pos", 64'(beat_idx % PL), 7);
        do_reset("mid");
        for (int i = 0; i < 20; i++) fq.push_back(32'h2000 + DW'(i));
        drain(100);
        chk("mid_pkts", 64'(pkt_count), 1);
        chk("mid_pkts1", 64'(pkt_count1), 20);
        chk("mid_busy", 64'(busy), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fifo_axis_reader
